// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU-to-RAM memory controller.
// Holds the state encoding, default widths and the timeout-counter sizing helper.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DFLT  = 16;
  localparam int unsigned DATA_W_DFLT  = 16;
  localparam int unsigned TIMEOUT_DFLT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter only has to reach TIMEOUT-1, so TIMEOUT+1 codes is always enough.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return unsigned'($clog2(timeout + 1));
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundles around the memory controller: CPU control side and RAM side.
// The controller is the slave of the CPU bundle and the master of the RAM bundle.
interface mem_cpu_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              I_execute;
  logic              I_we;
  logic [ADDR_W-1:0] I_addr;
  logic [DATA_W-1:0] I_data;
  logic              O_ready;
  logic              O_data_ready;
  logic [DATA_W-1:0] O_data;
  logic              O_error;

  modport master (
    output I_execute, I_we, I_addr, I_data,
    input  O_ready, O_data_ready, O_data, O_error
  );

  modport slave (
    input  I_execute, I_we, I_addr, I_data,
    output O_ready, O_data_ready, O_data, O_error
  );
endinterface

interface mem_ram_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              O_mem_req;
  logic              O_mem_we;
  logic [ADDR_W-1:0] O_mem_addr;
  logic [DATA_W-1:0] O_mem_wdata;
  logic              I_mem_ack;
  logic [DATA_W-1:0] I_mem_rdata;

  modport master (
    output O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata,
    input  I_mem_ack, I_mem_rdata
  );

  modport slave (
    input  O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata,
    output I_mem_ack, I_mem_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: turns one-cycle execute pulses into a RAM req/ack transaction
// with a timeout abort; every output is a flop.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DFLT,
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned TIMEOUT = TIMEOUT_DFLT
) (
  input logic       I_clk,
  input logic       I_reset,
  mem_cpu_if.slave  cpu,
  mem_ram_if.master ram
);

  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic               ready_d;
  logic               data_ready_d;
  logic [DATA_W-1:0]  data_d;
  logic               error_d;
  logic               req_d;
  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;

  logic               timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // State, counter and output registers
  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      cpu.O_ready      <= 1'b1;
      cpu.O_data_ready <= 1'b0;
      cpu.O_data       <= '0;
      cpu.O_error      <= 1'b0;
      ram.O_mem_req    <= 1'b0;
      ram.O_mem_we     <= 1'b0;
      ram.O_mem_addr   <= '0;
      ram.O_mem_wdata  <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cpu.O_ready      <= ready_d;
      cpu.O_data_ready <= data_ready_d;
      cpu.O_data       <= data_d;
      cpu.O_error      <= error_d;
      ram.O_mem_req    <= req_d;
      ram.O_mem_we     <= we_d;
      ram.O_mem_addr   <= addr_d;
      ram.O_mem_wdata  <= wdata_d;
    end
  end

  // Next-state logic; an ack on the threshold cycle still counts as success
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cpu.I_execute) state_d = ST_REQ;
      ST_REQ:  if (ram.I_mem_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; results hold until the next accepted execute
  always_comb begin
    cnt_d        = cnt_q;
    data_ready_d = cpu.O_data_ready;
    data_d       = cpu.O_data;
    error_d      = cpu.O_error;
    we_d         = ram.O_mem_we;
    addr_d       = ram.O_mem_addr;
    wdata_d      = ram.O_mem_wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu.I_execute) begin
          we_d         = cpu.I_we;
          addr_d       = cpu.I_addr;
          wdata_d      = cpu.I_data;
          data_ready_d = 1'b0;
          error_d      = 1'b0;
          cnt_d        = '0;
        end
      end
      ST_REQ: begin
        if (ram.I_mem_ack) begin
          data_ready_d = 1'b1;
          if (!ram.O_mem_we) data_d = ram.I_mem_rdata;
        end else if (timeout_hit) begin
          // Aborted transaction reads back as all-ones
          data_ready_d = 1'b1;
          error_d      = 1'b1;
          data_d       = '1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    ready_d = (state_d == ST_IDLE);
    req_d   = (state_d == ST_REQ);
  end

endmodule
